pulse_interval_monitor: RTL and testbench

//  Downstream consumer of the random pulse generator's pulse output; characterises the pulse train.

---
 rtl/pulse_pkg.sv | 23 ++
 rtl/pulse_interval_monitor_if.sv | 28 ++
 rtl/pulse_edge_detect.sv | 21 ++
 rtl/pulse_interval_monitor.sv | 163 ++++++++++++++++
 tb/tb_pulse_interval_monitor.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse interval monitor: readout select codes,
// FSM state encoding and default widths.
package pulse_pkg;

  localparam int CNT_W_DEF         = 16;
  localparam int WIN_W_DEF         = 8;
  localparam int WINDOW_CYCLES_DEF = 1024;

  localparam logic [2:0] RD_LAST_LO = 3'd0;
  localparam logic [2:0] RD_LAST_HI = 3'd1;
  localparam logic [2:0] RD_MIN_LO  = 3'd2;
  localparam logic [2:0] RD_MIN_HI  = 3'd3;
  localparam logic [2:0] RD_MAX_LO  = 3'd4;
  localparam logic [2:0] RD_MAX_HI  = 3'd5;
  localparam logic [2:0] RD_WIN     = 3'd6;
  localparam logic [2:0] RD_STATUS  = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/pulse_interval_monitor_if.sv
// Bundle of control inputs and result outputs of the pulse interval monitor.
interface pulse_interval_monitor_if;
  import pulse_pkg::*;

  // There is no valid/ready pair. Inputs are sampled on every rising clk edge.
  // data_out is always valid and reflects rd_sel of the previous cycle.
  // win_valid is a one-cycle strobe marking a freshly closed window; the
  // consumer cannot stall it.
  logic       ena;
  logic       pulse_in;
  logic       clear;
  logic [2:0] rd_sel;
  logic [7:0] data_out;
  logic       win_valid;
  logic       ovf;
  state_e     dbg_state;

  modport master (
    output ena, pulse_in, clear, rd_sel,
    input  data_out, win_valid, ovf, dbg_state
  );

  modport slave (
    input  ena, pulse_in, clear, rd_sel,
    output data_out, win_valid, ovf, dbg_state
  );

endinterface

// File: rtl/pulse_edge_detect.sv
// Registers the incoming pulse and flags its rising edge.
// The register follows the input every cycle, independent of enable or clear,
// so a level held across a disable/enable boundary never looks like an edge.
module pulse_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pulse,
  output logic o_rise
);

  logic r_pulse_q;

  // Previous-cycle copy of the pulse level.
  always_ff @(posedge clk) begin
    if (!rst_n) r_pulse_q <= 1'b0;
    else        r_pulse_q <= i_pulse;
  end

  assign o_rise = i_pulse & ~r_pulse_q;

endmodule

// File: rtl/pulse_interval_monitor.sv
// Characterises a pulse train: the interval between successive rising edges
// (last/min/max), the pulse count per fixed window, and a registered byte
// readout of all results.
module pulse_interval_monitor
  import pulse_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEF,
  parameter int WINDOW_CYCLES = WINDOW_CYCLES_DEF,
  parameter int WIN_W         = WIN_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pulse_interval_monitor_if.slave  bus
);

  localparam int                TW       = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [WIN_W-1:0]  WIN_MAX  = {WIN_W{1'b1}};
  localparam logic [TW-1:0]     WIN_LAST = TW'(WINDOW_CYCLES - 1);

  logic             w_rise;
  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_start;
  logic             w_capture;
  logic             w_count;
  logic [CNT_W-1:0] r_ivl_cnt;
  logic [CNT_W-1:0] r_last_ivl;
  logic [CNT_W-1:0] r_min_ivl;
  logic [CNT_W-1:0] r_max_ivl;
  logic             r_ovf;
  logic [TW-1:0]    r_win_timer;
  logic [WIN_W-1:0] r_win_cnt;
  logic [WIN_W-1:0] r_win_result;
  logic [WIN_W-1:0] w_win_sum;
  logic             r_win_valid;
  logic [7:0]       w_rd_mux;
  logic [7:0]       r_data_out;
  logic [15:0]      w_last16;
  logic [15:0]      w_min16;
  logic [15:0]      w_max16;

  pulse_edge_detect u_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_pulse (bus.pulse_in),
    .o_rise  (w_rise)
  );

  // FSM state register; clear returns to IDLE and wins over any rise.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clear) r_state <= ST_IDLE;
    else                     r_state <= w_state_nxt;
  end

  // FSM next state and the interval-counter controls it produces.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_capture   = 1'b0;
    w_count     = 1'b0;
    if (bus.ena) begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            w_state_nxt = ST_RUN;
            w_start     = 1'b1;
          end
        end
        ST_RUN: begin
          if (w_rise) w_capture = 1'b1;
          else        w_count   = 1'b1;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Interval counter and last/min/max statistics. The counter starts at 1 on
  // the rise cycle, so a captured value is the distance between rise cycles.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clear) begin
      r_ivl_cnt  <= '0;
      r_last_ivl <= '0;
      r_min_ivl  <= CNT_MAX;
      r_max_ivl  <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_start) r_ivl_cnt <= CNT_ONE;
      if (w_capture) begin
        r_last_ivl <= r_ivl_cnt;
        if (r_ivl_cnt < r_min_ivl) r_min_ivl <= r_ivl_cnt;
        if (r_ivl_cnt > r_max_ivl) r_max_ivl <= r_ivl_cnt;
        r_ivl_cnt <= CNT_ONE;
      end
      if (w_count) begin
        // Overflow is flagged only when the counter would have to exceed its
        // maximum, so an interval of exactly CNT_MAX is still exact.
        if (r_ivl_cnt == CNT_MAX) r_ovf     <= 1'b1;
        else                      r_ivl_cnt <= r_ivl_cnt + CNT_ONE;
      end
    end
  end

  // Saturating pulse count including a rise in the current cycle.
  assign w_win_sum = (w_rise && (r_win_cnt != WIN_MAX)) ? r_win_cnt + WIN_W'(1) : r_win_cnt;

  // Window timer and per-window pulse count; a rise on the boundary cycle
  // belongs to the window that is closing.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clear) begin
      r_win_timer  <= '0;
      r_win_cnt    <= '0;
      r_win_result <= '0;
      r_win_valid  <= 1'b0;
    end else if (bus.ena) begin
      r_win_valid <= (r_win_timer == WIN_LAST);
      if (r_win_timer == WIN_LAST) begin
        r_win_timer  <= '0;
        r_win_result <= w_win_sum;
        r_win_cnt    <= '0;
      end else begin
        r_win_timer <= r_win_timer + TW'(1);
        r_win_cnt   <= w_win_sum;
      end
    end else begin
      r_win_valid <= 1'b0;
    end
  end

  assign w_last16 = 16'(r_last_ivl);
  assign w_min16  = 16'(r_min_ivl);
  assign w_max16  = 16'(r_max_ivl);

  // Readout selection from current register contents.
  always_comb begin
    w_rd_mux = 8'h00;
    case (bus.rd_sel)
      RD_LAST_LO: w_rd_mux = w_last16[7:0];
      RD_LAST_HI: w_rd_mux = w_last16[15:8];
      RD_MIN_LO:  w_rd_mux = w_min16[7:0];
      RD_MIN_HI:  w_rd_mux = w_min16[15:8];
      RD_MAX_LO:  w_rd_mux = w_max16[7:0];
      RD_MAX_HI:  w_rd_mux = w_max16[15:8];
      RD_WIN:     w_rd_mux = 8'(r_win_result);
      RD_STATUS:  w_rd_mux = {r_ovf, (r_state == ST_RUN), 6'b0};
      default:    w_rd_mux = 8'h00;
    endcase
  end

  // Registered readout byte, one cycle behind rd_sel.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clear) r_data_out <= 8'h00;
    else                     r_data_out <= w_rd_mux;
  end

  assign bus.data_out  = r_data_out;
  assign bus.win_valid = r_win_valid;
  assign bus.ovf       = r_ovf;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_pulse_interval_monitor.sv
// Bench for pulse_interval_monitor. Two instances share one stimulus stream:
// a 16-bit interval counter and a 4-bit one (to reach saturation quickly),
// both with a 16-cycle window. A timestamp-based reference model predicts the
// outputs after every clock edge.
module tb_pulse_interval_monitor;
  import pulse_pkg::*;

  localparam int WIN_CYC = 16;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  pulse_interval_monitor_if bus_a ();
  pulse_interval_monitor_if bus_b ();

  pulse_interval_monitor #(.CNT_W(16), .WINDOW_CYCLES(WIN_CYC), .WIN_W(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  pulse_interval_monitor #(.CNT_W(4), .WINDOW_CYCLES(WIN_CYC), .WIN_W(8)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Record layout: {data_out[7:0], win_valid, ovf, state_is_run}
  logic [10:0] exp_q_a[$];
  logic [10:0] exp_q_b[$];

  int   m_max[2];
  logic m_pq[2];
  int   m_t[2];        // count of enabled cycles seen
  int   m_trise[2];    // enabled-cycle index of the last accepted rise
  logic m_run[2];
  int   m_last[2];
  int   m_min[2];
  int   m_max_ivl[2];
  logic m_ovf[2];
  int   m_wt[2];       // enabled cycles since window start
  int   m_wcnt[2];
  int   m_wres[2];
  logic m_wv[2];
  logic [7:0] m_dout[2];

  task automatic model_clear(input int k);
    m_run[k]     = 1'b0;
    m_last[k]    = 0;
    m_min[k]     = m_max[k];
    m_max_ivl[k] = 0;
    m_ovf[k]     = 1'b0;
    m_wt[k]      = 0;
    m_wcnt[k]    = 0;
    m_wres[k]    = 0;
    m_wv[k]      = 1'b0;
    m_dout[k]    = 8'h00;
  endtask

  task automatic model_step(input int k, input logic rn, input logic en,
                            input logic pl, input logic cl, input logic [2:0] rs);
    logic       rise;
    int         ivl;
    int         cap;
    logic [7:0] rd;
    logic [10:0] rec;
    rise   = pl & ~m_pq[k];
    m_pq[k] = rn ? pl : 1'b0;
    case (rs)
      3'd0:    rd = 8'(m_last[k] % 256);
      3'd1:    rd = 8'((m_last[k] / 256) % 256);
      3'd2:    rd = 8'(m_min[k] % 256);
      3'd3:    rd = 8'((m_min[k] / 256) % 256);
      3'd4:    rd = 8'(m_max_ivl[k] % 256);
      3'd5:    rd = 8'((m_max_ivl[k] / 256) % 256);
      3'd6:    rd = 8'(m_wres[k]);
      default: rd = (m_ovf[k] ? 8'h80 : 8'h00) | (m_run[k] ? 8'h40 : 8'h00);
    endcase
    if (!rn || cl) begin
      model_clear(k);
    end else begin
      m_dout[k] = rd;
      m_wv[k]   = 1'b0;
      if (en) begin
        m_t[k] = m_t[k] + 1;
        if (m_run[k]) begin
          ivl = m_t[k] - m_trise[k];
          if (rise) begin
            cap = (ivl > m_max[k]) ? m_max[k] : ivl;
            m_last[k] = cap;
            if (cap < m_min[k])     m_min[k] = cap;
            if (cap > m_max_ivl[k]) m_max_ivl[k] = cap;
            m_trise[k] = m_t[k];
          end else if (ivl >= m_max[k]) begin
            m_ovf[k] = 1'b1;
          end
        end else if (rise) begin
          m_run[k]   = 1'b1;
          m_trise[k] = m_t[k];
        end
        if (m_wt[k] == WIN_CYC - 1) begin
          m_wres[k] = (m_wcnt[k] + int'(rise) > 255) ? 255 : m_wcnt[k] + int'(rise);
          m_wcnt[k] = 0;
          m_wt[k]   = 0;
          m_wv[k]   = 1'b1;
        end else begin
          m_wcnt[k] = (m_wcnt[k] + int'(rise) > 255) ? 255 : m_wcnt[k] + int'(rise);
          m_wt[k]   = m_wt[k] + 1;
        end
      end
    end
    rec = {m_dout[k], m_wv[k], m_ovf[k], m_run[k]};
    if (k == 0) exp_q_a.push_back(rec);
    else        exp_q_b.push_back(rec);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic rn, input logic en, input logic pl,
                     input logic cl, input logic [2:0] rs);
    @(negedge clk);
    rst_n          = rn;
    bus_a.ena      = en;  bus_b.ena      = en;
    bus_a.pulse_in = pl;  bus_b.pulse_in = pl;
    bus_a.clear    = cl;  bus_b.clear    = cl;
    bus_a.rd_sel   = rs;  bus_b.rd_sel   = rs;
    model_step(0, rn, en, pl, cl, rs);
    model_step(1, rn, en, pl, cl, rs);
  endtask

  task automatic idle(input int n, input logic pl, input logic [2:0] rs);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, pl, 1'b0, rs);
  endtask

  task automatic read_all();
    for (int s = 0; s < 8; s++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'(s));
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [10:0] mon_e_a, mon_act_a, mon_e_b, mon_act_b;

  always @(posedge clk) begin
    #2;
    if (exp_q_a.size() > 0) begin
      mon_e_a   = exp_q_a.pop_front();
      mon_act_a = {bus_a.data_out, bus_a.win_valid, bus_a.ovf, (bus_a.dbg_state == ST_RUN)};
      n_cmp++;
      if (mon_act_a !== mon_e_a) begin
        n_fail++;
        $display("FAIL out_cnt16 t=%0t got dout=%h wv=%b ovf=%b run=%b expected dout=%h wv=%b ovf=%b run=%b",
                 $time, mon_act_a[10:3], mon_act_a[2], mon_act_a[1], mon_act_a[0],
                 mon_e_a[10:3], mon_e_a[2], mon_e_a[1], mon_e_a[0]);
      end
    end
    if (exp_q_b.size() > 0) begin
      mon_e_b   = exp_q_b.pop_front();
      mon_act_b = {bus_b.data_out, bus_b.win_valid, bus_b.ovf, (bus_b.dbg_state == ST_RUN)};
      n_cmp++;
      if (mon_act_b !== mon_e_b) begin
        n_fail++;
        $display("FAIL out_cnt4 t=%0t got dout=%h wv=%b ovf=%b run=%b expected dout=%h wv=%b ovf=%b run=%b",
                 $time, mon_act_b[10:3], mon_act_b[2], mon_act_b[1], mon_act_b[0],
                 mon_e_b[10:3], mon_e_b[2], mon_e_b[1], mon_e_b[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic       r_pl;
  logic       r_en;
  logic       r_cl;
  logic       r_rn;
  logic [2:0] r_rs;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    m_max  = '{65535, 15};
    for (int k = 0; k < 2; k++) begin
      m_pq[k]    = 1'b0;
      m_t[k]     = 0;
      m_trise[k] = 0;
      model_clear(k);
    end
    rst_n          = 1'b0;
    bus_a.ena      = 1'b0;  bus_b.ena      = 1'b0;
    bus_a.pulse_in = 1'b0;  bus_b.pulse_in = 1'b0;
    bus_a.clear    = 1'b0;  bus_b.clear    = 1'b0;
    bus_a.rd_sel   = 3'd0;  bus_b.rd_sel   = 3'd0;

    // Reset values, including min reading all-ones and an idle status byte.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd2);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd3);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd7);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);

    // Intervals 10, 5, 20 between rises.
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 3'd0);
    for (int i = 0; i < 50; i++)
      cyc(1'b1, 1'b1, (i == 10 || i == 20 || i == 25 || i == 45), 1'b0, 3'(i % 8));
    read_all();

    // Window with three rises, the last on the boundary cycle.
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 3'd6);
    for (int i = 0; i < 40; i++)
      cyc(1'b1, 1'b1, (i == 3 || i == 8 || i == 15), 1'b0, 3'd6);

    // Long quiet interval saturates the narrow counter; ovf stays until clear.
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 3'd7);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 3'd7);
    idle(20, 1'b0, 3'd7);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 3'd7);
    read_all();
    idle(10, 1'b0, 3'd7);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 3'd7);
    idle(3, 1'b0, 3'd7);

    // Clear coinciding with a rise; the following rise only arms.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 3'd7);
    idle(3, 1'b0, 3'd7);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
    read_all();

    // Disabled span with pulse held high; no edge on re-enable.
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 3'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
    idle(5, 1'b0, 3'd7);
    for (int i = 0; i < 50; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 3'd7);
    idle(3, 1'b1, 3'd7);
    idle(6, 1'b0, 3'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
    read_all();

    // Randomized traffic.
    r_pl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) r_pl = ~r_pl;
      r_cl = ($urandom_range(0, 299) == 0);
      r_rn = ($urandom_range(0, 799) != 0);
      r_rs = 3'($urandom_range(0, 7));
      cyc(r_rn, r_en, r_pl, r_cl, r_rs);
    end
    // Sparse pulses so the narrow counter saturates during random traffic too.
    for (int i = 0; i < 600; i++) begin
      r_pl = ($urandom_range(0, 24) == 0);
      r_rs = 3'($urandom_range(0, 7));
      cyc(1'b1, ($urandom_range(0, 19) != 0), r_pl, 1'b0, r_rs);
    end

    // Drain and confirm every expected record was consumed.
    repeat (2) @(posedge clk);
    #3;
    n_cmp++;
    if ((exp_q_a.size() + exp_q_b.size()) != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending records, expected 0", exp_q_a.size() + exp_q_b.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
